// File: rtl/pc_flow_sequencer.sv
// ----------------------------------------------------------------------------
// pc_flow_sequencer
//
// Fetch/decode/execute control sequencer for the CPU program counter.
// Requests the instruction at the current PC, hands it to decode, accepts one
// control-flow command and issues exactly one PC control pulse for it. The
// return-stack occupancy of the PC block is tracked here so that a call into
// a full stack or a ret from an empty one becomes a sticky fault instead of a
// silent pointer wrap. Also provides halt/resume and a fetch timeout.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   pc_value          current PC value from the PC block
//   imem_req/addr     instruction fetch request and address (addr = PC while req)
//   imem_ack/data     fetch completion and fetched instruction
//   instr/instr_valid latched instruction and one-cycle "new instruction" pulse
//   cmd_ready/valid   command handshake with decode
//   cmd_type/target   command code (0 seq,1 branch,2 jump,3 call,4 ret,5 halt)
//   pc_update..pc_ret one-hot PC control pulses, pc_target jump address
//   resume            leave the halted state
//   stack_depth       mirrored return-stack occupancy
//   halted            sequencer is halted
//   fault/fault_code  sticky fault (1 ovf, 2 unf, 3 illegal, 4 fetch timeout)
// ----------------------------------------------------------------------------
module pc_flow_sequencer #(
  parameter int ADDR_W        = 19,
  parameter int STACK_DEPTH   = 16,
  parameter int DEPTH_W       = 5,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [ADDR_W-1:0]  imem_data,
  output logic [ADDR_W-1:0]  instr,
  output logic               instr_valid,
  output logic               cmd_ready,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_type,
  input  logic [ADDR_W-1:0]  cmd_target,
  output logic               pc_update,
  output logic               pc_branch,
  output logic               pc_jump,
  output logic               pc_call,
  output logic               pc_ret,
  output logic [ADDR_W-1:0]  pc_target,
  input  logic               resume,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic               halted,
  output logic               fault,
  output logic [2:0]         fault_code
);

  localparam int TMO_W = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED, S_FAULT
  } state_t;

  localparam logic [2:0] CMD_SEQ    = 3'd0;
  localparam logic [2:0] CMD_BRANCH = 3'd1;
  localparam logic [2:0] CMD_JUMP   = 3'd2;
  localparam logic [2:0] CMD_CALL   = 3'd3;
  localparam logic [2:0] CMD_RET    = 3'd4;
  localparam logic [2:0] CMD_HALT   = 3'd5;

  localparam logic [2:0] FC_OVERFLOW  = 3'd1;
  localparam logic [2:0] FC_UNDERFLOW = 3'd2;
  localparam logic [2:0] FC_ILLEGAL   = 3'd3;
  localparam logic [2:0] FC_TIMEOUT   = 3'd4;

  // Bit positions inside the pulse vector.
  localparam int P_UPDATE = 0;
  localparam int P_BRANCH = 1;
  localparam int P_JUMP   = 2;
  localparam int P_CALL   = 3;
  localparam int P_RET    = 4;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [4:0]         pulse_q, pulse_d;
  logic [ADDR_W-1:0]  instr_d, pc_target_d;
  logic               instr_valid_d;
  logic [2:0]         fault_code_d;

  wire stack_full  = (stack_depth == DEPTH_W'(STACK_DEPTH));
  wire stack_empty = (stack_depth == '0);

  // The only combinational output: the PC is passed straight through so the
  // fetch address is valid in the same cycle the request is raised.
  assign imem_addr = imem_req ? pc_value : '0;

  assign pc_update = pulse_q[P_UPDATE];
  assign pc_branch = pulse_q[P_BRANCH];
  assign pc_jump   = pulse_q[P_JUMP];
  assign pc_call   = pulse_q[P_CALL];
  assign pc_ret    = pulse_q[P_RET];

  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    pulse_d       = '0;
    instr_d       = instr;
    instr_valid_d = 1'b0;
    pc_target_d   = pc_target;
    fault_code_d  = fault_code;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_data;
          instr_valid_d = 1'b1;
          tmo_d         = '0;
          state_d       = S_DECODE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          // This cycle is the FETCH_TIMEOUT-th one without an ack.
          if (tmo_q == TMO_W'(FETCH_TIMEOUT - 1)) begin
            state_d      = S_FAULT;
            fault_code_d = FC_TIMEOUT;
          end
        end
      end

      S_DECODE: begin
        if (cmd_valid) begin
          pc_target_d = cmd_target;
          state_d     = S_EXEC;
          case (cmd_type)
            CMD_SEQ:    pulse_d[P_UPDATE] = 1'b1;
            CMD_BRANCH: pulse_d[P_BRANCH] = 1'b1;
            CMD_JUMP:   pulse_d[P_JUMP]   = 1'b1;
            CMD_CALL: begin
              if (stack_full) begin
                state_d      = S_FAULT;
                fault_code_d = FC_OVERFLOW;
              end else begin
                pulse_d[P_CALL] = 1'b1;
              end
            end
            CMD_RET: begin
              if (stack_empty) begin
                state_d      = S_FAULT;
                fault_code_d = FC_UNDERFLOW;
              end else begin
                pulse_d[P_RET] = 1'b1;
              end
            end
            CMD_HALT: state_d = S_HALTED;
            default: begin
              state_d      = S_FAULT;
              fault_code_d = FC_ILLEGAL;
            end
          endcase
        end
      end

      S_EXEC: state_d = S_FETCH;

      // Resuming advances the PC past the halt instruction.
      S_HALTED: begin
        if (resume) begin
          state_d           = S_EXEC;
          pulse_d[P_UPDATE] = 1'b1;
        end
      end

      // FAULT is terminal until reset; resume has no effect.
      default: state_d = S_FAULT;
    endcase
  end

  // Registered outputs are loaded from the next state so they are valid for
  // the whole cycle the FSM spends in that state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      pulse_q     <= '0;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      cmd_ready   <= 1'b0;
      pc_target   <= '0;
      stack_depth <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      pulse_q     <= pulse_d;
      imem_req    <= (state_d == S_FETCH);
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      cmd_ready   <= (state_d == S_DECODE);
      pc_target   <= pc_target_d;
      halted      <= (state_d == S_HALTED);
      fault       <= (state_d == S_FAULT);
      fault_code  <= fault_code_d;
      // The depth follows the PC block, which pushes/pops on the edge that
      // ends the EXEC cycle carrying the pulse. Range was checked in DECODE.
      if (pulse_q[P_CALL])
        stack_depth <= stack_depth + 1'b1;
      else if (pulse_q[P_RET])
        stack_depth <= stack_depth - 1'b1;
    end
  end

endmodule

// File: doc/pc_flow_sequencer.md
Name: pc_flow_sequencer

Overview:
Control sequencer for the 19-bit CPU program counter. Runs the fetch/decode/execute loop: requests the instruction at the current PC, hands it to decode, and accepts one control-flow command. It then drives exactly one PC control pulse (update/branch/jump/call/ret) per instruction. It mirrors the PC's 16-entry return-stack depth, converting would-be overflow/underflow into a sticky fault instead of silent pointer wrap. It also provides halt/resume and a fetch timeout.

Parameters:
ADDR_W, 19, address/instruction width
STACK_DEPTH, 16, return-stack entries in the PC block
DEPTH_W, 5, width of depth counter (holds 0..STACK_DEPTH)
FETCH_TIMEOUT, 255, max wait cycles for imem_ack before fault

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
pc_value  in  ADDR_W  current PC output
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address
imem_ack  in  1  fetch complete, imem_data valid this cycle
imem_data  in  ADDR_W  fetched instruction
instr  out  ADDR_W  latched instruction to decode
instr_valid  out  1  one-cycle pulse, new instr available
cmd_ready  out  1  sequencer accepts a command
cmd_valid  in  1  decode presents a command
cmd_type  in  3  0 seq, 1 branch_taken, 2 jump, 3 call, 4 ret, 5 halt, 6/7 illegal
cmd_target  in  ADDR_W  target for branch/jump/call
pc_update, pc_branch, pc_jump, pc_call, pc_ret  out  1 each  one-hot PC control pulses
pc_target  out  ADDR_W  jump address to PC
resume  in  1  leave HALTED
stack_depth  out  DEPTH_W  current return-stack occupancy
halted  out  1  in HALTED state
fault  out  1  sticky fault flag
fault_code  out  3  0 none, 1 overflow, 2 underflow, 3 illegal cmd, 4 fetch timeout

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0: imem_req, instr, instr_valid, cmd_ready, all pc_* pulses, pc_target, stack_depth, halted, fault, fault_code. Timeout counter 0. Reset mid-fetch drops imem_req the same instant.
- All outputs are registered except imem_addr. imem_addr = pc_value combinationally while imem_req=1, else 0.
- States: IDLE, FETCH, DECODE, EXEC, HALTED, FAULT.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - imem_req=1.
  - When imem_ack=1: latch instr<=imem_data, go to DECODE, and clear the timeout counter.
  - When imem_ack=0: increment the counter. When the counter reaches FETCH_TIMEOUT, go to FAULT with code 4.
  - imem_ack outside FETCH is ignored.
- DECODE:
  - instr_valid=1 on the first DECODE cycle only. instr holds until the next ack.
  - cmd_ready=1.
  - When cmd_valid=1, evaluate the command:
    - seq, branch_taken, jump: go to EXEC.
    - call with stack_depth==STACK_DEPTH: go to FAULT, code 1, no pulse.
    - call otherwise: go to EXEC.
    - ret with stack_depth==0: go to FAULT, code 2, no pulse.
    - ret otherwise: go to EXEC.
    - halt: go to HALTED, no pulse.
    - 6/7: go to FAULT, code 3.
  - pc_target<=cmd_target is captured on acceptance for every cmd.
- EXEC: exactly one cycle. Exactly one pulse is high:
  - seq → pc_update
  - branch_taken → pc_branch
  - jump → pc_jump
  - call → pc_call, stack_depth+1
  - ret → pc_ret, stack_depth−1
  - Next state is FETCH.
- HALTED: halted=1, no requests. When resume=1, go to EXEC with pc_update (advance past halt), halted cleared the same edge.
- FAULT: fault=1, fault_code held, imem_req=0, no pulses, cmd_ready=0. resume is ignored. Exit only by reset.
- Pulses: pc_* are never high outside EXEC and never two at once.
- Minimum throughput: 3 cycles per instruction (FETCH with immediate ack, DECODE with immediate cmd_valid, EXEC).
- stack_depth changes only in EXEC. It never wraps, and stays in 0..STACK_DEPTH.
- cmd_valid while cmd_ready=0 is ignored; decode must hold it.

Test Plan:
- Reset release, pc_value=0x00010, imem_ack same cycle as first req, data 0x12345, cmd seq → imem_addr=0x00010; instr=0x12345 with instr_valid pulse; pc_update one pulse exactly 3 cycles after FETCH entry; back to FETCH.
- cmd jump, target 0x7FFFF → pc_jump single pulse, pc_target=0x7FFFF, no other pc_* asserted, stack_depth unchanged.
- 16 calls → stack_depth=16. 17th call → fault=1, fault_code=1, no pc_call pulse, imem_req stays 0. Reset → stack_depth=0, fault=0.
- ret at depth 0 → fault_code=2. Separately: call, ret, ret → depth 1, 0, then fault_code=2.
- imem_ack withheld 255 cycles → fault_code=4. Variant with ack at cycle 254 → no fault, normal DECODE.
- halt cmd → halted=1, no pulse. resume after 10 cycles → one pc_update, then FETCH. Reset asserted mid-FETCH → imem_req falls asynchronously, all outputs 0.
